// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone widths, FSM state encodings and state type for the round-robin arbiter.
// The optional grant timeout is enabled by defining WB_ARB_TIMEOUT_EN.
`ifndef WB_DEF_V
`define WB_DEF_V
`define WB_AW 32
`define WB_DW 32
`define WB_SELW 4
`define WB_ARB_ST_IDLE 1'b0
`define WB_ARB_ST_GRANT 1'b1
`endif

package wb_arbiter_pkg;

    localparam int AW   = `WB_AW;
    localparam int DW   = `WB_DW;
    localparam int SELW = `WB_SELW;

    typedef enum logic {
        ST_IDLE  = `WB_ARB_ST_IDLE,
        ST_GRANT = `WB_ARB_ST_GRANT
    } arbState_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// The arbiter uses the slave modport; whatever drives the masters and models the slave uses master.
interface wb_arbiter_if #(
    parameter int NM = 4
);
    import wb_arbiter_pkg::*;

    logic [NM-1:0]      m_cyc_i;
    logic [NM-1:0]      m_stb_i;
    logic [NM-1:0]      m_we_i;
    logic [NM*AW-1:0]   m_addr_i;
    logic [NM*SELW-1:0] m_sel_i;
    logic [NM*DW-1:0]   m_data_i;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;
    logic [DW-1:0]      m_data_o;
    logic               s_cyc_o;
    logic               s_stb_o;
    logic               s_we_o;
    logic [AW-1:0]      s_addr_o;
    logic [SELW-1:0]    s_sel_o;
    logic [DW-1:0]      s_data_o;
    logic               s_ack_i;
    logic [DW-1:0]      s_data_i;
    logic [NM-1:0]      gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_sel_i, m_data_i, s_ack_i, s_data_i,
        output m_ack_o, m_err_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o,
               s_data_o, gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_sel_i, m_data_i, s_ack_i, s_data_i,
        input  m_ack_o, m_err_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o,
               s_data_o, gnt_o
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning last+1, last+2, ... modulo NM.
module wb_rr_pick #(
    parameter int NM = 4
) (
    input  logic [NM-1:0]         i_req,
    input  logic [$clog2(NM)-1:0] i_last,
    output logic [NM-1:0]         o_gnt,
    output logic [$clog2(NM)-1:0] o_idx
);
    localparam int IW = $clog2(NM);

    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NM; k++) begin
            w_cand = IW'((int'(i_last) + 1 + k) % NM);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave, one grant per master bus cycle.
// Defining WB_ARB_TIMEOUT_EN revokes a grant after TO_CYCLES unacknowledged strobe cycles.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NM        = 4,
    parameter int TO_CYCLES = 16
) (
    input logic        clk_i,
    input logic        rst_i,
    wb_arbiter_if.slave bus
);
    localparam int IW = $clog2(NM);

    arbState_t     r_state;
    logic [NM-1:0] r_gnt;
    logic [IW-1:0] r_last;

    logic [NM-1:0] w_pickGnt;
    logic [IW-1:0] w_pickIdx;
    logic          w_inGrant;
    logic          w_gCyc;

    wb_rr_pick #(.NM(NM)) u_pick (
        .i_req  (bus.m_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pickGnt),
        .o_idx  (w_pickIdx)
    );

    assign w_inGrant    = (r_state == ST_GRANT);
    assign w_gCyc       = |(bus.m_cyc_i & r_gnt);
    assign bus.gnt_o    = r_gnt;
    assign bus.m_data_o = bus.s_data_i;

    // Everything on the slave side reads as zero unless some master holds the grant.
    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_addr_o = '0;
        bus.s_sel_o  = '0;
        bus.s_data_o = '0;
        bus.m_ack_o  = '0;
        for (int i = 0; i < NM; i++) begin
            if (w_inGrant && r_gnt[i]) begin
                bus.s_cyc_o   = bus.m_cyc_i[i];
                bus.s_stb_o   = bus.m_stb_i[i];
                bus.s_we_o    = bus.m_we_i[i];
                bus.s_addr_o  = bus.m_addr_i[i*AW +: AW];
                bus.s_sel_o   = bus.m_sel_i[i*SELW +: SELW];
                bus.s_data_o  = bus.m_data_i[i*DW +: DW];
                bus.m_ack_o[i] = bus.s_ack_i & bus.m_cyc_i[i] & bus.m_stb_i[i];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES) + 1;

    logic [CW-1:0] r_toCnt;
    logic [NM-1:0] r_err;

    assign bus.m_err_o = r_err;
`else
    assign bus.m_err_o = '0;

    // The timeout length only matters when the feature is built in.
    if (TO_CYCLES < 2) begin : g_toCyclesIgnored
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= IW'(NM - 1);
`ifdef WB_ARB_TIMEOUT_EN
            r_toCnt <= '0;
            r_err   <= '0;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            r_err <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|bus.m_cyc_i) begin
                        r_gnt   <= w_pickGnt;
                        r_last  <= w_pickIdx;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_gCyc) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
                        r_toCnt <= '0;
`endif
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    // r_last already holds the stalled master, so it drops to lowest priority.
                    else if (bus.s_stb_o && !bus.s_ack_i) begin
                        if (r_toCnt == CW'(TO_CYCLES - 1)) begin
                            r_err   <= r_gnt;
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                            r_toCnt <= '0;
                        end else begin
                            r_toCnt <= r_toCnt + CW'(1);
                        end
                    end else if (bus.s_ack_i) begin
                        r_toCnt <= '0;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter with hand sequences for hold, timeout and reset.
// Expectations for the timeout sequence follow WB_ARB_TIMEOUT_EN when it is defined.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NM        = 4;
    localparam int TO_CYCLES = 16;

    typedef struct packed {
        logic [3:0] cyc;
        logic [3:0] stb;
        logic [3:0] we;
        logic       ack;
        logic [3:0] expGnt;
        logic [3:0] expAck;
        logic       expSCyc;
    } vec_t;

    logic clk_i;
    logic rst_i;

    wb_arbiter_if #(.NM(NM)) bus ();

    wb_arbiter #(.NM(NM), .TO_CYCLES(TO_CYCLES)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    vec_t        vecs[$];
    int          compareCount  = 0;
    int          mismatchCount = 0;
    logic [31:0] slaveData;
    logic [31:0] addrTab [NM];
    logic [31:0] dataTab [NM];
    logic [3:0]  selTab  [NM];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard stop in case the run stalls somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic [3:0] cyc, input logic [3:0] stb,
                                   input logic [3:0] we, input logic ack,
                                   input logic [3:0] expGnt, input logic [3:0] expAck,
                                   input logic expSCyc);
        vecs.push_back({cyc, stb, we, ack, expGnt, expAck, expSCyc});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic [3:0] cyc, input logic [3:0] stb,
                                 input logic [3:0] we, input logic ack);
        @(negedge clk_i);
        bus.m_cyc_i = cyc;
        bus.m_stb_i = stb;
        bus.m_we_i  = we;
        bus.s_ack_i = ack;
        slaveData   = $urandom();
        bus.s_data_i = slaveData;
        #1;
    endtask

    task automatic checkVector(input int n, input vec_t v);
        int idx;
        idx = -1;
        for (int k = 0; k < NM; k++)
            if (v.expGnt[k]) idx = k;
        checkOutput($sformatf("v%0d gnt", n),    64'(bus.gnt_o),   64'(v.expGnt));
        checkOutput($sformatf("v%0d m_ack", n),  64'(bus.m_ack_o), 64'(v.expAck));
        checkOutput($sformatf("v%0d s_cyc", n),  64'(bus.s_cyc_o), 64'(v.expSCyc));
        checkOutput($sformatf("v%0d s_stb", n),  64'(bus.s_stb_o), 64'((idx >= 0) ? v.stb[idx] : 1'b0));
        checkOutput($sformatf("v%0d s_we", n),   64'(bus.s_we_o),  64'((idx >= 0) ? v.we[idx] : 1'b0));
        checkOutput($sformatf("v%0d s_addr", n), 64'(bus.s_addr_o), 64'((idx >= 0) ? addrTab[idx] : 32'h0));
        checkOutput($sformatf("v%0d s_sel", n),  64'(bus.s_sel_o),  64'((idx >= 0) ? selTab[idx] : 4'h0));
        checkOutput($sformatf("v%0d s_data", n), 64'(bus.s_data_o), 64'((idx >= 0) ? dataTab[idx] : 32'h0));
        checkOutput($sformatf("v%0d m_err", n),  64'(bus.m_err_o), 64'(0));
        checkOutput($sformatf("v%0d m_data", n), 64'(bus.m_data_o), 64'(slaveData));
    endtask

    initial begin
        addrTab = '{32'h0000_0100, 32'h0000_0010, 32'h0000_0200, 32'h0000_0300};
        dataTab = '{32'h1111_1111, 32'hA5A5_A5A5, 32'h2222_2222, 32'h3333_3333};
        selTab  = '{4'h1, 4'hF, 4'h3, 4'hC};
        for (int i = 0; i < NM; i++) begin
            bus.m_addr_i[i*32 +: 32] = addrTab[i];
            bus.m_data_i[i*32 +: 32] = dataTab[i];
            bus.m_sel_i[i*4 +: 4]    = selTab[i];
        end

        // Round robin from reset, every master re-requesting right after its ack.
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1);
        addVec(4'b1110, 4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1);
        addVec(4'b1101, 4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1);
        addVec(4'b1011, 4'b1111, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1);
        addVec(4'b0111, 4'b1111, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1);
        addVec(4'b1110, 4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Master 1 writes 0xA5A5A5A5 to 0x10, slave acks on the third granted cycle.
        addVec(4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1);
        addVec(4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1);
        addVec(4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Slave ack while idle is ignored, even with a request pending.
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Master 2 keeps cyc with stb low: grant held, ack gated by stb.
        addVec(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        addVec(4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1);
        addVec(4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Reset state, with every master requesting and the slave acking.
        rst_i        = 1'b1;
        bus.m_cyc_i  = 4'b1111;
        bus.m_stb_i  = 4'b1111;
        bus.m_we_i   = 4'b1111;
        bus.s_ack_i  = 1'b1;
        slaveData    = 32'h0;
        bus.s_data_i = slaveData;
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("reset gnt",    64'(bus.gnt_o),    64'(0));
        checkOutput("reset s_cyc",  64'(bus.s_cyc_o),  64'(0));
        checkOutput("reset s_addr", 64'(bus.s_addr_o), 64'(0));
        checkOutput("reset m_ack",  64'(bus.m_ack_o),  64'(0));
        checkOutput("reset m_err",  64'(bus.m_err_o),  64'(0));
        @(negedge clk_i);
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.s_ack_i = 1'b0;
        rst_i       = 1'b0;

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].cyc, vecs[n].stb, vecs[n].we, vecs[n].ack);
            checkVector(n, vecs[n]);
        end

        // Master 2 holds its cycle for 10 cycles while master 0 waits.
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
        checkOutput("hold pre gnt", 64'(bus.gnt_o), 64'(0));
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0101, 4'b0101, 4'b0000, 1'b0);
            checkOutput($sformatf("hold%0d gnt", k),  64'(bus.gnt_o),    64'(4'b0100));
            checkOutput($sformatf("hold%0d addr", k), 64'(bus.s_addr_o), 64'(32'h200));
        end
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0);
        checkOutput("hold drop gnt", 64'(bus.gnt_o),   64'(4'b0100));
        checkOutput("hold drop cyc", 64'(bus.s_cyc_o), 64'(0));
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0);
        checkOutput("hold bubble gnt", 64'(bus.gnt_o), 64'(0));
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
        checkOutput("hold m0 gnt", 64'(bus.gnt_o),   64'(4'b0001));
        checkOutput("hold m0 ack", 64'(bus.m_ack_o), 64'(4'b0001));
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("hold end gnt", 64'(bus.gnt_o), 64'(0));

        // Master 1 strobes with no slave ack.
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] expGnt;
            logic [3:0] expErr;
            expGnt = 4'b0010;
            expErr = 4'b0000;
`ifdef WB_ARB_TIMEOUT_EN
            if (k == TO_CYCLES + 1) begin
                expGnt = 4'b0000;
                expErr = 4'b0010;
            end
`endif
            applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0);
            checkOutput($sformatf("noack%0d gnt", k), 64'(bus.gnt_o),   64'(expGnt));
            checkOutput($sformatf("noack%0d err", k), 64'(bus.m_err_o), 64'(expErr));
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("noack end gnt", 64'(bus.gnt_o), 64'(0));

        // Reset mid-transfer of master 3 with master 0 also requesting.
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0);
        applyStimulus(4'b1001, 4'b1001, 4'b1000, 1'b0);
        checkOutput("rst pre gnt",  64'(bus.gnt_o),    64'(4'b1000));
        checkOutput("rst pre addr", 64'(bus.s_addr_o), 64'(32'h300));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("rst async s_cyc",  64'(bus.s_cyc_o),  64'(0));
        checkOutput("rst async gnt",    64'(bus.gnt_o),    64'(0));
        checkOutput("rst async s_addr", 64'(bus.s_addr_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(4'b1001, 4'b1001, 4'b1000, 1'b0);
        checkOutput("rst after gnt", 64'(bus.gnt_o), 64'(4'b0001));
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0);
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0);
        checkOutput("rst bubble gnt", 64'(bus.gnt_o), 64'(0));
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b0);
        checkOutput("rst m3 gnt", 64'(bus.gnt_o), 64'(4'b1000));
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin Wishbone bus arbiter: NM masters share one slave port.
- Grants the bus to one requesting master per bus cycle and multiplexes that master's cyc/stb/we/addr/sel/data onto the slave side.
- Routes ack back to the granted master only; slave read data is broadcast to all masters.
- Sits between multiple wb_master-style initiators and a single Wishbone slave or interconnect.

Parameters:
- NM, 4, number of masters (2..8).
- TO_CYCLES, 16, cycles with stb high and no ack before timeout (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- m_cyc_i  in  NM  per-master cyc.
- m_stb_i  in  NM  per-master stb.
- m_we_i  in  NM  per-master we.
- m_addr_i  in  NM*`aw  packed master addresses; master i occupies bits [i*`aw +: `aw].
- m_sel_i  in  NM*`selw  packed byte selects.
- m_data_i  in  NM*`dw  packed master write data.
- m_ack_o  out  NM  per-master ack.
- m_err_o  out  NM  per-master timeout error.
- m_data_o  out  `dw  slave read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side strobes.
- s_addr_o  out  `aw  slave address.
- s_sel_o  out  `selw  slave byte select.
- s_data_o  out  `dw  slave write data.
- s_ack_i  in  1  slave ack.
- s_data_i  in  `dw  slave read data.
- gnt_o  out  NM  one-hot current grant, registered.

Behaviour:
- Reset (asynchronous, rst_i high):
  - state=IDLE, gnt_o=0, last=NM-1 so master 0 has top priority first.
  - Timeout counter=0, m_err_o=0.
  - All s_* outputs 0, m_ack_o=0.
- IDLE:
  - If any m_cyc_i bit is high, select the first requester scanning last+1, last+2, ... modulo NM.
  - On that clock edge: set gnt_o to the one-hot selection, last=selected index, go to GRANT.
  - If no requests, stay in IDLE and keep gnt_o=0.
- GRANT (g = granted index):
  - Combinational mux: s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g], s_we_o=m_we_i[g]; addr/sel/data come from slice g.
  - m_ack_o[g] = s_ack_i & m_cyc_i[g] & m_stb_i[g]; all other m_ack_o bits are 0.
  - When m_cyc_i[g] is sampled low, go to IDLE and clear gnt_o. This gives one mandatory bubble cycle between grants.
- Outside GRANT, all s_* outputs are forced to 0, including addr, sel and data. s_ack_i is ignored there; no m_ack_o is generated.
- Latency: master cyc asserted at edge N → gnt_o and s_cyc_o valid after edge N+1. This adds 1 cycle to every transaction.
- Fairness: a master that just completed has lowest priority for the next arbitration. With all NM masters requesting, grants rotate 0,1,2,3,0...
- Grant is held for the master's entire cyc; a long burst is never preempted without the optional feature.
- A master dropping stb while holding cyc keeps the grant.
- Simultaneous s_ack_i and master cyc deassertion in the same cycle: the ack is still routed combinationally; the state returns to IDLE at that edge.
- rst_i asserted mid-transfer: the slave side is released immediately (asynchronously); the transfer is lost.
- m_data_o = s_data_i at all times.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - In GRANT, a counter increments each cycle with s_stb_o=1 and s_ack_i=0, and clears on ack or on leaving GRANT.
  - When the count reaches TO_CYCLES-1, on that edge: pulse m_err_o[g] for exactly one cycle and go to IDLE (forcing s_cyc_o=0).
  - last=g, so other requesters win next.
  - If the master still holds cyc, it is re-arbitrated normally.
- Without the macro: no counter; m_err_o is tied to 0 and grants are never revoked.

Decomposition:
- Shared definitions stay in wb_def.v (`aw, `dw, `selw); add `define for the IDLE/GRANT state encodings there.
- One natural sub-module: wb_rr_pick. It is combinational: inputs NM-bit request vector and last index; outputs one-hot grant plus index.
- wb_arbiter instantiates wb_rr_pick and holds the FSM, the mux and the timeout counter.

Test Plan:
- Single master 1 writes addr 0x10, data 0xA5A5A5A5, slave acks after 2 cycles:
  - gnt_o=0010 one cycle after cyc.
  - Slave sees addr 0x10 and data 0xA5A5A5A5.
  - Only m_ack_o[1] pulses.
- All 4 masters request continuously, each releasing after ack → grant order 0,1,2,3,0 with one IDLE bubble between grants.
- Master 2 holds cyc for 10 cycles while master 0 requests → master 0 waits; gnt_o stays 0100 until master 2 drops cyc.
- Reset pulsed mid-transfer while master 3 is granted → s_cyc_o=0 and gnt_o=0 immediately. Then master 0 is granted first, even with 0 and 3 both requesting.
- Slave never acks, WB_ARB_TIMEOUT_EN defined, TO_CYCLES=16 → m_err_o[g] pulses once after 16 stb cycles and the FSM returns to IDLE. Without the macro, the grant is held indefinitely.
- Ack to non-granted master: s_ack_i asserted while IDLE → all m_ack_o stay 0.
